// File: rtl/button_logic_rgb.sv
// button_logic_rgb: debounced buttons drive a logic op, a saturating level bar and RGB mode LEDs; define BUTTON_LOGIC_RGB_PWM_EN for PWM dimming
module button_logic_rgb #(
    parameter int LED_W           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btnc,
    input  logic             btnl,
    input  logic             btnr,
    input  logic             btnu,
    input  logic             btnd,
    output logic [LED_W-1:0] led,
    output logic             led16_r,
    output logic             led16_g,
    output logic             led16_b,
    output logic             led17_r,
    output logic             led17_g,
    output logic             led17_b
);
    localparam int N  = LED_W - 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [4:0]   raw, s1, s2, deb;
    logic [2:0]   cud, cud_q, rise;
    logic [1:0]   mode;
    logic [N-1:0] level;
    logic         op, on;
    logic [2:0]   colour;

    assign raw = {btnd, btnu, btnr, btnl, btnc};
    assign cud = {deb[4], deb[3], deb[0]};

    // two-flop synchroniser for the raw button pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          state;
        assign deb[g] = state;
        // state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt   <= '0;
                state <= 1'b0;
            end else if (s2[g] == state) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // registered rise pulses for C, U and D
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cud_q <= '0;
            rise  <= '0;
        end else begin
            cud_q <= cud;
            rise  <= cud & ~cud_q;
        end
    end

    // mode wraps naturally; level saturates and ignores simultaneous U+D
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode  <= '0;
            level <= '0;
        end else begin
            mode <= mode + {1'b0, rise[0]};
            if (rise[1] && !rise[2] && level != '1)
                level <= level + 1'b1;
            else if (rise[2] && !rise[1] && level != '0)
                level <= level - 1'b1;
        end
    end

    // selected logic operation and mode colour
    always_comb begin
        op     = mode == 2'd0 ? deb[1] ^ deb[2] :
                 mode == 2'd1 ? deb[1] & deb[2] :
                 mode == 2'd2 ? deb[1] | deb[2] : ~(deb[1] & deb[2]);
        colour = mode == 2'd0 ? 3'b100 :
                 mode == 2'd1 ? 3'b010 :
                 mode == 2'd2 ? 3'b001 : 3'b111;
    end

`ifdef BUTTON_LOGIC_RGB_PWM_EN
    logic [N-1:0] pwm_cnt;
    // free-running PWM ramp compared against the level
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end
    assign on = pwm_cnt < level;
`else
    assign on = 1'b1;
`endif

    // output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led                         <= '0;
            {led16_r, led16_g, led16_b} <= '0;
            {led17_r, led17_g, led17_b} <= '0;
        end else begin
            led                         <= {level, op};
            {led16_r, led16_g, led16_b} <= colour & {3{on}};
            {led17_r, led17_g, led17_b} <= {op, deb[1], deb[2]} & {3{on}};
        end
    end
endmodule

// File: tb/tb_button_logic_rgb.sv
// tb_button_logic_rgb: directed table and sequence checks for button_logic_rgb
module tb_button_logic_rgb;
    logic       clk = 1'b0, reset = 1'b1;
    logic       btnc = 0, btnl = 0, btnr = 0, btnu = 0, btnd = 0;
    logic [4:0] led;
    logic       led16_r, led16_g, led16_b, led17_r, led17_g, led17_b;
    int         total = 0, bad = 0;

`ifdef BUTTON_LOGIC_RGB_PWM_EN
    localparam int G_ON = 4;
`else
    localparam int G_ON = 16;
`endif

    localparam logic [4:0] C = 5'b00001, L = 5'b00010, R = 5'b00100, U = 5'b01000, D = 5'b10000;

    button_logic_rgb #(.LED_W(5), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .btnc(btnc), .btnl(btnl), .btnr(btnr),
        .btnu(btnu), .btnd(btnd), .led(led),
        .led16_r(led16_r), .led16_g(led16_g), .led16_b(led16_b),
        .led17_r(led17_r), .led17_g(led17_g), .led17_b(led17_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] held;
        logic [4:0] press;
        logic [4:0] led;
        logic [2:0] c16;
        logic [2:0] c17;
    } vec_t;
    vec_t tv[9];

    task automatic set_btn(input logic [4:0] v);
        {btnd, btnu, btnr, btnl, btnc} = v;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic press(input logic [4:0] held, input logic [4:0] p);
        set_btn(held | p);
        cyc(8);
        set_btn(held);
        cyc(10);
    endtask

    function automatic int rgb16();
        return {led16_r, led16_g, led16_b};
    endfunction

    function automatic int rgb17();
        return {led17_r, led17_g, led17_b};
    endfunction

    initial begin
        int n, cnt_g, cnt_r;
        logic seen;
        tv[0] = '{L,     5'b0, 5'b00001, 3'b100, 3'b110};
        tv[1] = '{L,     C,    5'b00000, 3'b010, 3'b010};
        tv[2] = '{L,     C,    5'b00001, 3'b001, 3'b110};
        tv[3] = '{L,     C,    5'b00001, 3'b111, 3'b110};
        tv[4] = '{L,     C,    5'b00001, 3'b100, 3'b110};
        tv[5] = '{L,     C,    5'b00000, 3'b010, 3'b010};
        tv[6] = '{L | R, 5'b0, 5'b00001, 3'b010, 3'b111};
        tv[7] = '{R,     5'b0, 5'b00000, 3'b010, 3'b001};
        tv[8] = '{5'b0,  5'b0, 5'b00000, 3'b010, 3'b000};

        cyc(3);
        check("reset_led", led, 0);
        check("reset_rgb16", rgb16(), 0);
        check("reset_rgb17", rgb17(), 0);
        reset = 1'b0;
        cyc(3);
        check("post_reset_led", led, 0);
`ifndef BUTTON_LOGIC_RGB_PWM_EN
        check("post_reset_red", rgb16(), 3'b100);
`endif

        seen = 1'b0;
        set_btn(L);
        cyc(3);
        set_btn(5'b0);
        repeat (12) begin
            cyc(1);
            seen |= led[0];
        end
        check("glitch_led0", seen, 0);

        set_btn(L);
        n = 0;
        while (!led[0] && n < 20) begin
            cyc(1);
            n++;
        end
        check("l_latency_ok", (n >= 6 && n <= 7), 1);

        for (int i = 0; i < 9; i++) begin
            set_btn(tv[i].held);
            if (tv[i].press != 0)
                press(tv[i].held, tv[i].press);
            else
                cyc(18);
            check($sformatf("tv%0d_led", i), led, tv[i].led);
`ifndef BUTTON_LOGIC_RGB_PWM_EN
            check($sformatf("tv%0d_rgb16", i), rgb16(), tv[i].c16);
            check($sformatf("tv%0d_rgb17", i), rgb17(), tv[i].c17);
`endif
        end

        for (int k = 1; k <= 17; k++) begin
            press(5'b0, U);
            check($sformatf("up%0d", k), led, {4'(k < 15 ? k : 15), 1'b0});
        end
        press(5'b0, U | D);
        check("ud_at_max", led, 5'b11110);
        press(5'b0, D);
        check("down_to_14", led, 5'b11100);
        press(5'b0, U | D);
        check("ud_at_14", led, 5'b11100);
        press(5'b0, U);
        check("up_to_15", led, 5'b11110);
        for (int k = 1; k <= 16; k++) begin
            press(5'b0, D);
            check($sformatf("down%0d", k), led, {4'(k < 15 ? 15 - k : 0), 1'b0});
        end
        press(5'b0, D);
        check("down_floor", led, 0);

        repeat (4) press(5'b0, U);
        check("level4", led, 5'b01000);
        cnt_g = 0;
        cnt_r = 0;
        repeat (16) begin
            cyc(1);
            cnt_g += led16_g;
            cnt_r += led16_r;
        end
        check("pwm_green_on", cnt_g, G_ON);
        check("pwm_red_on", cnt_r, 0);

        set_btn(U | L);
        cyc(3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_led", led, 0);
        check("async_reset_rgb16", rgb16(), 0);
        check("async_reset_rgb17", rgb17(), 0);
        cyc(2);
        reset = 1'b0;
        cyc(20);
        check("held_after_reset", led, 5'b00011);
`ifndef BUTTON_LOGIC_RGB_PWM_EN
        check("held_after_reset_rgb16", rgb16(), 3'b100);
        check("held_after_reset_rgb17", rgb17(), 3'b110);
`endif
        set_btn(5'b0);
        cyc(20);
        check("release_no_action", led, 5'b00010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
